imm_gen_stage: RTL and testbench

- Parametrised next-generation immediate picker for the RV32IM pipeline, sitting between the ID decoder and the ID/EX boundary.
- Extracts and sign- or zero-extends the immediate to XLEN bits for every RISC-V format, plus shamt and CSR zimm.
- Registers the result, together with a sideband tag, through a 2-entry skid buffer with valid/ready handshake, stall back-pressure and flush.

---
 rtl/imm_pkg.sv | 24 ++
 rtl/imm_extract.sv | 49 ++++
 rtl/imm_gen_stage.sv | 128 ++++++++++++
 tb/tb_imm_gen_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared selector encodings and defaults for the immediate generator stage.
// The optional CSR zimm leg is controlled by IMM_GEN_ZIMM_EN in imm_extract.
package imm_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_U     = 3'b010;
    localparam logic [2:0] IMM_B     = 3'b011;
    localparam logic [2:0] IMM_J     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;
    localparam logic [2:0] IMM_ZIMM  = 3'b110;
    localparam logic [2:0] IMM_NONE  = 3'b111;

    // Occupancy of the skid buffer, encoded as {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_BAD   = 2'b01,
        BUF_ONE   = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational RISC-V immediate decode and extension to XLEN bits.
// IMM_GEN_ZIMM_EN enables the CSR zimm selector; otherwise it reports a format error.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int SEL_W = 3
) (
    input  logic [31:0]      inst_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [XLEN-1:0]  imm_o,
    output logic             fmt_err_o
);

    logic signed [11:0] i_imm;
    logic signed [11:0] s_imm;
    logic signed [31:0] u_imm;
    logic signed [12:0] b_imm;
    logic signed [20:0] j_imm;
    logic        [5:0]  shamt;
    logic               unused_opcode;

    assign i_imm = inst_i[31:20];
    assign s_imm = {inst_i[31:25], inst_i[11:7]};
    assign u_imm = {inst_i[31:12], 12'b0};
    assign b_imm = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign j_imm = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    // RV64 shifts use a 6-bit shamt; RV32 keeps bit 25 out of the result.
    assign shamt = (XLEN == 64) ? inst_i[25:20] : {1'b0, inst_i[24:20]};
    assign unused_opcode = ^inst_i[6:0];

    always_comb begin
        imm_o     = '0;
        fmt_err_o = 1'b0;
        case (sel_i)
            IMM_I:     imm_o = XLEN'(i_imm);
            IMM_S:     imm_o = XLEN'(s_imm);
            IMM_U:     imm_o = XLEN'(u_imm);
            IMM_B:     imm_o = XLEN'(b_imm);
            IMM_J:     imm_o = XLEN'(j_imm);
            IMM_SHAMT: imm_o = XLEN'(shamt);
`ifdef IMM_GEN_ZIMM_EN
            IMM_ZIMM:  imm_o = XLEN'(inst_i[19:15]);
`endif
            default:   fmt_err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate picker registered through a 2-entry valid/ready skid buffer with flush.
// Build option IMM_GEN_ZIMM_EN (see imm_extract) enables the CSR zimm selector.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = 8,
    parameter int SEL_W = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INSTRUCTION,
    input  logic [SEL_W-1:0] IMM_PICK,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  IMMEDIATE,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             OUT_FMT_ERR
);

    // Handshake: a side transfers on a cycle where its valid and ready are both 1.
    // IN_READY is a flop (!skid_valid) so it never follows OUT_READY combinationally.

    logic [XLEN-1:0]  ext_imm;
    logic             ext_err;

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  main_imm_q, main_imm_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             main_err_q, main_err_d;
    logic             skid_err_q, skid_err_d;
    logic             in_fire;
    logic             out_fire;
    buf_state_e       buf_state;

    imm_extract #(
        .XLEN  (XLEN),
        .SEL_W (SEL_W)
    ) u_extract (
        .inst_i    (INSTRUCTION),
        .sel_i     (IMM_PICK),
        .imm_o     (ext_imm),
        .fmt_err_o (ext_err)
    );

    assign in_fire   = IN_VALID && !skid_valid_q;
    assign out_fire  = main_valid_q && OUT_READY;
    assign buf_state = buf_state_e'({main_valid_q, skid_valid_q});

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_imm_d   = main_imm_q;
        main_tag_d   = main_tag_q;
        main_err_d   = main_err_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        if (FLUSH) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_valid_q && !out_fire) begin
            if (in_fire) begin
                skid_valid_d = 1'b1;
                skid_imm_d   = ext_imm;
                skid_tag_d   = IN_TAG;
                skid_err_d   = ext_err;
            end
        end else if (skid_valid_q) begin
            // Skid full implies IN_READY was low, so no input competes for main.
            main_valid_d = 1'b1;
            main_imm_d   = skid_imm_q;
            main_tag_d   = skid_tag_q;
            main_err_d   = skid_err_q;
            skid_valid_d = 1'b0;
        end else if (in_fire) begin
            main_valid_d = 1'b1;
            main_imm_d   = ext_imm;
            main_tag_d   = IN_TAG;
            main_err_d   = ext_err;
        end else begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_tag_q   <= '0;
            main_err_q   <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_imm_q   <= main_imm_d;
            main_tag_q   <= main_tag_d;
            main_err_q   <= main_err_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
        end
    end

    assign IN_READY    = !skid_valid_q;
    assign OUT_VALID   = main_valid_q;
    assign IMMEDIATE   = main_imm_q;
    assign OUT_TAG     = main_tag_q;
    assign OUT_FMT_ERR = main_err_q;

    a_out_hold: assert property (@(posedge CLK) disable iff (RESET)
        (OUT_VALID && !OUT_READY && !FLUSH) |=>
        (OUT_VALID && $stable(IMMEDIATE) && $stable(OUT_TAG) && $stable(OUT_FMT_ERR)));

    a_no_skid_only: assert property (@(posedge CLK) disable iff (RESET)
        buf_state != BUF_BAD);

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage (XLEN=32, TAG_W=8) with an expected-result queue.
module tb_imm_gen_stage;

    localparam int XLEN  = 32;
    localparam int TAG_W = 8;
    localparam int EW    = 1 + XLEN + TAG_W;

    logic             clk;
    logic             RESET;
    logic             FLUSH;
    logic             IN_VALID;
    logic             IN_READY;
    logic [31:0]      INSTRUCTION;
    logic [2:0]       IMM_PICK;
    logic [TAG_W-1:0] IN_TAG;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [XLEN-1:0]  IMMEDIATE;
    logic [TAG_W-1:0] OUT_TAG;
    logic             OUT_FMT_ERR;

    logic [EW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic          rand_ready = 1'b0;
    logic          prev_stall = 1'b0;
    logic [EW:0]   prev_out   = '0;

    imm_gen_stage #(.XLEN(XLEN), .TAG_W(TAG_W), .SEL_W(3)) dut (
        .CLK         (clk),
        .RESET       (RESET),
        .FLUSH       (FLUSH),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .INSTRUCTION (INSTRUCTION),
        .IMM_PICK    (IMM_PICK),
        .IN_TAG      (IN_TAG),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .IMMEDIATE   (IMMEDIATE),
        .OUT_TAG     (OUT_TAG),
        .OUT_FMT_ERR (OUT_FMT_ERR)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] model(input logic [31:0] i, input logic [2:0] p,
                                            input logic [TAG_W-1:0] t);
        logic [31:0] v;
        logic        e;
        v = 32'd0;
        e = 1'b0;
        case (p)
            3'd0: v = {{20{i[31]}}, i[31:20]};
            3'd1: v = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2: v = {i[31:12], 12'h000};
            3'd3: v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4: v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd5: v = {27'd0, i[24:20]};
`ifdef IMM_GEN_ZIMM_EN
            3'd6: v = {27'd0, i[19:15]};
`endif
            default: e = 1'b1;
        endcase
        return {e, v, t};
    endfunction

    // driver tasks: entered and left at posedge + #1
    task automatic send(input logic [31:0] inst, input logic [2:0] pick, input logic [TAG_W-1:0] tag);
        int budget;
        budget      = 200;
        INSTRUCTION = inst;
        IMM_PICK    = pick;
        IN_TAG      = tag;
        IN_VALID    = 1'b1;
        forever begin
            @(negedge clk);
            if (IN_READY || budget == 0) break;
            budget--;
        end
        if (budget == 0) check("in_ready_timeout", 64'(IN_READY), 64'd1);
        else exp_q.push_back(model(inst, pick, tag));
        @(posedge clk);
        #1 IN_VALID = 1'b0;
    endtask

    task automatic send_expect(input logic [31:0] inst, input logic [2:0] pick,
                               input logic [TAG_W-1:0] tag, input logic [31:0] exp_imm,
                               input logic exp_err, input string name);
        send(inst, pick, tag);
        @(negedge clk);
        check({name, "_valid"}, 64'(OUT_VALID), 64'd1);
        check({name, "_imm"}, 64'(IMMEDIATE), 64'(exp_imm));
        check({name, "_err"}, 64'(OUT_FMT_ERR), 64'(exp_err));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        budget = 500;
        while ((exp_q.size() != 0 || OUT_VALID) && budget > 0) begin
            @(posedge clk);
            #1 budget--;
        end
        if (budget == 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2 if (rand_ready) OUT_READY = 1'($urandom_range(0, 1));
        end
    end

    // scoreboard: pops on every output transfer, and checks holds under stall
    always @(negedge clk) begin
        logic [EW-1:0] exp;
        if (prev_stall)
            check("hold", 64'({OUT_VALID, OUT_FMT_ERR, IMMEDIATE, OUT_TAG}), 64'(prev_out));
        if (!RESET && !FLUSH && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(OUT_TAG), 64'hFFFF);
            end else begin
                exp = exp_q.pop_front();
                check("out", 64'({OUT_FMT_ERR, IMMEDIATE, OUT_TAG}), 64'(exp));
            end
        end
        prev_stall = !RESET && !FLUSH && OUT_VALID && !OUT_READY;
        prev_out   = {1'b1, OUT_FMT_ERR, IMMEDIATE, OUT_TAG};
    end

    initial begin
        RESET       = 1'b1;
        FLUSH       = 1'b0;
        IN_VALID    = 1'b0;
        INSTRUCTION = 32'd0;
        IMM_PICK    = 3'd0;
        IN_TAG      = '0;
        OUT_READY   = 1'b1;
        repeat (3) @(posedge clk);
        #1 RESET = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_in_ready", 64'(IN_READY), 64'd1);
        check("rst_imm", 64'(IMMEDIATE), 64'd0);
        check("rst_tag", 64'(OUT_TAG), 64'd0);
        check("rst_err", 64'(OUT_FMT_ERR), 64'd0);
        @(posedge clk);
        #1;

        // directed formats, one-cycle latency from an empty buffer
        send_expect(32'hFE000F80, 3'b011, 8'h10, 32'hFFFFFFFE, 1'b0, "b_type");
        send_expect(32'h87654321, 3'b100, 8'h11, 32'hFFF54076, 1'b0, "j_type");
        send_expect(32'hFFF00000, 3'b000, 8'h12, 32'hFFFFFFFF, 1'b0, "i_type");
        send_expect(32'h00000FFF, 3'b010, 8'h13, 32'h00000000, 1'b0, "u_type");
        send_expect(32'hFE000F80, 3'b001, 8'h14, 32'hFFFFFFFF, 1'b0, "s_type");
        send_expect(32'h03F00013, 3'b101, 8'h15, 32'h0000001F, 1'b0, "shamt");
`ifdef IMM_GEN_ZIMM_EN
        send_expect(32'h000F8073, 3'b110, 8'h16, 32'h0000001F, 1'b0, "zimm");
`else
        send_expect(32'h000F8073, 3'b110, 8'h16, 32'h00000000, 1'b1, "zimm");
`endif
        send_expect(32'hFFFFFFFF, 3'b111, 8'h17, 32'h00000000, 1'b1, "none");

        // back-pressure: two transfers fill the buffer, the third waits
        drain();
        OUT_READY = 1'b0;
        send(32'h00100093, 3'b000, 8'd1);
        send(32'h00200113, 3'b000, 8'd2);
        @(negedge clk);
        check("bp_full_in_ready", 64'(IN_READY), 64'd0);
        fork
            send(32'h00300193, 3'b000, 8'd3);
            begin
                repeat (3) @(negedge clk);
                check("bp_held_in_ready", 64'(IN_READY), 64'd0);
                @(posedge clk);
                #1 OUT_READY = 1'b1;
            end
        join
        drain();

        // flush a full buffer while a new input is offered
        OUT_READY = 1'b0;
        send(32'h00500293, 3'b000, 8'h21);
        send(32'h00600313, 3'b000, 8'h22);
        INSTRUCTION = 32'h00700393;
        IMM_PICK    = 3'b000;
        IN_TAG      = 8'h23;
        IN_VALID    = 1'b1;
        FLUSH       = 1'b1;
        @(posedge clk);
        #1 FLUSH = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", 64'(OUT_VALID), 64'd0);
        check("flush_in_ready", 64'(IN_READY), 64'd1);
        @(posedge clk);
        #1;
        send_expect(32'h80000013, 3'b000, 8'h24, 32'hFFFFF800, 1'b0, "post_flush");

        // reset mid-stream with the skid slot occupied
        OUT_READY = 1'b0;
        send(32'hFFF00013, 3'b000, 8'h31);
        send(32'hFFF00013, 3'b111, 8'h32);
        RESET = 1'b1;
        @(posedge clk);
        #1 RESET = 1'b0;
        OUT_READY = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("mid_rst_in_ready", 64'(IN_READY), 64'd1);
        check("mid_rst_imm", 64'(IMMEDIATE), 64'd0);
        check("mid_rst_tag", 64'(OUT_TAG), 64'd0);
        check("mid_rst_err", 64'(OUT_FMT_ERR), 64'd0);
        @(posedge clk);
        #1;
        send_expect(32'h7FF00013, 3'b000, 8'h33, 32'h000007FF, 1'b0, "post_reset");

        // random stream with random downstream stalls
        rand_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            send($urandom, 3'($urandom_range(0, 7)), 8'(k));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1 OUT_READY = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
